// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/freeze control for the 5-stage RV32I pipe.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   id_rs1/rs2, id_use_*   source registers of the ID instruction
//   id_is_branch           ID instruction resolves in ID (branch/JALR)
//   id_redirect            ID resolved a taken branch/jump this cycle
//   ex_rd, ex_mem_read     producer in EX and whether it is a load
//   mem_rd, mem_mem_read   producer in MEM and whether it is a load
//   dmem_req, dmem_ready   data-memory handshake of the MEM stage
//   pc_en .. mem_wb_bubble per-stage enables / bubbles
//   dmem_timeout           sticky "memory never answered" flag
//   hz_state               0 = RUN, 1 = STALL
//   stall_cycles           stall + freeze cycles (HAZARD_PERF_EN)
//   flush_count            IF/ID flushes (HAZARD_PERF_EN)
module hazard_ctrl #(
  parameter int DMEM_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_branch,
  input  logic             id_redirect,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_mem_read,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             dmem_timeout,
  output logic             hz_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (DMEM_TIMEOUT < 1) ? 1
                        : $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX =
    WAIT_W'(DMEM_TIMEOUT);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        stall_cnt;
  logic [1:0]        stall_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              timeout_nxt;

  logic       hit_e;
  logic       hit_m;
  logic       ld_e_br;
  logic       ld_e_alu;
  logic       ld_m_br;
  logic [1:0] n_stall;
  logic       freeze;
  logic       stalling;

  // x0 is hard-wired zero, so a write to it never creates a dependency
  assign hit_e = (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (ex_rd == id_rs1)) ||
                  (id_use_rs2 && (ex_rd == id_rs2)));

  assign hit_m = (mem_rd != 5'd0) &&
                 ((id_use_rs1 && (mem_rd == id_rs1)) ||
                  (id_use_rs2 && (mem_rd == id_rs2)));

  // mutually exclusive so the decoder below can be unique
  assign ld_e_br  = ex_mem_read && hit_e && id_is_branch;
  assign ld_e_alu = ex_mem_read && hit_e && !id_is_branch;
  assign ld_m_br  = mem_mem_read && hit_m && id_is_branch &&
                    !(ex_mem_read && hit_e);

  always_comb begin
    n_stall = 2'd0;
    unique case (1'b1)
      ld_e_br:  n_stall = 2'd2;
      ld_e_alu: n_stall = 2'd1;
      ld_m_br:  n_stall = 2'd1;
      default:  n_stall = 2'd0;
    endcase
  end

  assign freeze   = dmem_req && !dmem_ready;
  assign stalling = (state == STALL) || (n_stall != 2'd0);
  assign hz_state = (state == STALL);

  logic do_rst;
  logic do_frz;
  logic do_stl;

  assign do_rst = !rst_n;
  assign do_frz = rst_n && freeze;
  assign do_stl = rst_n && !freeze && stalling;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    unique case (1'b1)
      do_rst: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_bubble  = 1'b1;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      do_frz: begin
        // whole pipe holds; MEM/WB drains a bubble
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      do_stl: begin
        // hold IF/ID, inject a bubble into EX
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_bubble  = 1'b1;
      end
      default: begin
        // a redirect only counts once its branch really resolved
        if_id_flush = id_redirect;
      end
    endcase
  end

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    if (!freeze) begin
      if (state == STALL) begin
        if (stall_cnt <= 2'd1) begin
          stall_cnt_nxt = 2'd0;
          state_nxt     = RUN;
        end else begin
          stall_cnt_nxt = stall_cnt - 2'd1;
        end
      end else if (n_stall == 2'd2) begin
        // first bubble is this cycle, one more from STALL
        state_nxt     = STALL;
        stall_cnt_nxt = 2'd1;
      end
    end
  end

  always_comb begin
    wait_nxt = '0;
    if (freeze) begin
      if (wait_cnt == WAIT_MAX) begin
        wait_nxt = wait_cnt;
      end else begin
        wait_nxt = wait_cnt + WAIT_W'(1);
      end
    end
    timeout_nxt = dmem_timeout ||
                  (freeze && (wait_nxt == WAIT_MAX));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      stall_cnt    <= 2'd0;
      wait_cnt     <= '0;
      dmem_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      stall_cnt    <= stall_cnt_nxt;
      wait_cnt     <= wait_nxt;
      dmem_timeout <= timeout_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (freeze || stalling) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (if_id_flush) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall, flush and freeze controller for the 5-stage RV32I pipeline. It is the counterpart to operand forwarding and handles the hazards forwarding cannot cover.
- Detects load-use and load-to-branch dependencies and inserts bubbles for a counted number of cycles.
- Flushes IF/ID on an ID-stage redirect.
- Freezes the pipe while data memory withholds ready.
- Drives the per-stage enables and bubbles consumed by the pipeline registers.

Parameters:
- DMEM_TIMEOUT, 255: freeze cycles after which dmem_timeout sets.
- CNT_W, 32: width of the performance counters.

Ports:
- clk input 1: clock, rising edge.
- rst_n input 1: synchronous active-low reset.
- id_rs1 input 5: rs1 of the instruction in ID.
- id_rs2 input 5: rs2 of the instruction in ID.
- id_use_rs1 input 1: ID instruction reads rs1.
- id_use_rs2 input 1: ID instruction reads rs2.
- id_is_branch input 1: ID instruction is a branch or JALR, resolved in ID.
- id_redirect input 1: ID resolved a taken branch or jump this cycle.
- ex_rd input 5: destination register of the instruction in EX.
- ex_mem_read input 1: EX instruction is a load.
- mem_rd input 5: destination register of the instruction in MEM.
- mem_mem_read input 1: MEM instruction is a load.
- dmem_req input 1: MEM stage has an active data-memory access.
- dmem_ready input 1: data memory completes the access this cycle.
- pc_en output 1: PC update enable.
- if_id_en output 1: IF/ID register load enable.
- if_id_flush output 1: IF/ID register loads a NOP.
- id_ex_en output 1: ID/EX register load enable.
- id_ex_bubble output 1: ID/EX register loads a NOP.
- ex_mem_en output 1: EX/MEM register load enable.
- mem_wb_bubble output 1: MEM/WB register loads a NOP.
- dmem_timeout output 1: sticky timeout error flag.
- hz_state output 1: 0 = RUN, 1 = STALL.
- stall_cycles output CNT_W: count of stall and freeze cycles.
- flush_count output CNT_W: count of flushes.

Behaviour:
- Reset is synchronous and active-low: sampled on the clk rising edge while rst_n = 0.
- Reset state:
  - state = RUN, stall_cnt = 0, wait_cnt = 0, dmem_timeout = 0, counters = 0.
  - While rst_n = 0: pc_en, if_id_en, id_ex_en and ex_mem_en are 0; id_ex_bubble and mem_wb_bubble are 1; if_id_flush is 0.
  - Reset asserted mid-stall or mid-freeze aborts immediately to RUN.
- Dependency matches (register x0 never matches):
  - hitE = ex_rd != 0 and ((id_use_rs1 and ex_rd == id_rs1) or (id_use_rs2 and ex_rd == id_rs2)).
  - hitM = the same match against mem_rd.
- Required stall cycles N:
  - ex_mem_read and hitE and id_is_branch: N = 2.
  - ex_mem_read and hitE, not a branch: N = 1.
  - mem_mem_read and hitM and id_is_branch: N = 1.
  - Otherwise N = 0.
  - Non-load EX/MEM producers never stall; they are covered by forwarding.
- freeze = dmem_req and not dmem_ready. Freeze has the highest priority, independent of state:
  - pc_en = if_id_en = id_ex_en = ex_mem_en = 0, mem_wb_bubble = 1, id_ex_bubble = 0, if_id_flush = 0.
  - state and stall_cnt hold.
  - wait_cnt increments, saturating. When it reaches DMEM_TIMEOUT, dmem_timeout sets and stays set until reset.
  - Freeze continues after timeout.
  - wait_cnt clears on any non-freeze cycle.
- RUN state, no freeze:
  - N = 0: all enables 1, bubbles 0.
  - N >= 1: pc_en = if_id_en = 0, id_ex_en = 1, id_ex_bubble = 1.
  - N = 2: next state STALL with stall_cnt = 1.
  - N = 1: remain in RUN; the next cycle re-evaluates and finds no hazard.
- STALL state, no freeze:
  - Same stall outputs as RUN with N >= 1. Dependency matches are ignored.
  - stall_cnt decrements; when it reaches 0 the next state is RUN.
- Flush:
  - if_id_flush = id_redirect and rst_n and not freeze and not stalling.
  - id_redirect is ignored while stalling or freezing; the branch has not yet resolved.
  - Flush and enables coexist: if_id_en = 1 and the loaded value is a NOP.
- Stall latency: zero; all outputs are combinational from state and inputs. The state updates on the clk edge.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_cycles increments on every cycle that is stalling or freezing.
  - flush_count increments on every if_id_flush.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both outputs are constant 0 and no counter registers are built.

Test Plan:
- Load x5 in EX with ex_mem_read=1, ex_rd=5; ALU instruction in ID with id_rs1=5 and id_use_rs1=1 -> exactly 1 cycle of pc_en=0 and id_ex_bubble=1; next cycle all enables 1; hz_state stays 0.
- Same as above with id_is_branch=1 -> 2 stall cycles; hz_state=1 on the second; RUN on the third.
- ex_rd=0 with a load and matching id_rs1=0 -> no stall; a load hit with id_use_rs2=0 on rs2 -> no stall.
- dmem_req=1 with dmem_ready=0 for 3 cycles during STALL with stall_cnt=1 -> 3 freeze cycles (ex_mem_en=0, mem_wb_bubble=1), then the remaining stall cycle, then RUN; stall_cycles=4 with HAZARD_PERF_EN defined.
- Hold freeze for 255 cycles with DMEM_TIMEOUT=255 -> dmem_timeout=1 after cycle 255 and still 1 after dmem_ready returns; cleared only by rst_n=0.
- id_redirect=1 with no hazard -> if_id_flush=1 and flush_count+1; id_redirect=1 during a freeze -> if_id_flush=0; rst_n=0 during STALL -> next cycle hz_state=0.
